// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between a BCD digit source and the bcd_to_bin converter.
interface bcd_to_bin_if #(
  parameter int BITS = 14
);
  logic            start;
  logic [3:0]      thousands;
  logic [3:0]      hundreds;
  logic [3:0]      tens;
  logic [3:0]      ones;
  logic [BITS-1:0] number;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, thousands, hundreds, tens, ones,
    input  number, busy, done, err
  );

  modport slave (
    input  start, thousands, hundreds, tens, ones,
    output number, busy, done, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BITS   = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_to_bin_if.slave  bus
);
  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     d_q;
  logic [BITS-1:0]   b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BITS-1:0]   number_q;
  logic              busy_q, done_q, err_q;

  logic [DW+BITS-1:0] sh;
  logic [DW-1:0]      d_nxt;
  logic [BITS-1:0]    b_nxt;
  logic               digits_ok;
  logic               last_iter;

  // Any digit that reached 8..15 after the shift gets 3 removed (inverse of add-3).
  function automatic logic [DW-1:0] dabble_fix(input logic [DW-1:0] d);
    logic [3:0] dig;
    dabble_fix = d;
    for (int i = 0; i < DIGITS; i++) begin
      dig = d[4*i +: 4];
      if (dig >= 4'd8) dabble_fix[4*i +: 4] = dig - 4'd3;
    end
  endfunction

  function automatic logic is_bcd(input logic [3:0] x);
    return x <= 4'd9;
  endfunction

  always_comb begin
    sh        = {d_q, b_q} >> 1;
    d_nxt     = dabble_fix(sh[DW+BITS-1:BITS]);
    b_nxt     = sh[BITS-1:0];
    digits_ok = is_bcd(bus.thousands) && is_bcd(bus.hundreds) &&
                is_bcd(bus.tens) && is_bcd(bus.ones);
    last_iter = (cnt_q == CNT_W'(BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && digits_ok) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      number_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (digits_ok) begin
              d_q    <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
              b_q    <= '0;
              cnt_q  <= '0;
              busy_q <= 1'b1;
              err_q  <= 1'b0;
            end else begin
              // Rejected request: report immediately, keep the previous result.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          d_q   <= d_nxt;
          b_q   <= b_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
        FINISH: begin
          number_q <= b_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.number = number_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin against a decimal-arithmetic reference model.
module tb_bcd_to_bin;
  localparam int BITS = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_num = 0;
  int   model_err = 0;

  bcd_to_bin_if #(.BITS(BITS)) bus ();

  bcd_to_bin #(.DIGITS(4), .BITS(BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Invariants sampled mid-cycle: busy/done exclusive, digit register drained on completion.
  always @(negedge clk) begin
    check("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
    if (bus.done && !bus.err) check("d_drained", {16'd0, dut.d_q}, 32'd0);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic bit valid_bcd(input int t, input int h, input int te, input int o);
    return (t <= 9) && (h <= 9) && (te <= 9) && (o <= 9);
  endfunction

  task automatic set_digits(input int t, input int h, input int te, input int o);
    bus.thousands = 4'(t);
    bus.hundreds  = 4'(h);
    bus.tens      = 4'(te);
    bus.ones      = 4'(o);
  endtask

  // One request; valid conversions return in the done cycle so the next call is back-to-back.
  task automatic apply(input int t, input int h, input int te, input int o);
    int lat;
    bit busy_ok;
    @(negedge clk);
    set_digits(t, h, te, o);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (valid_bcd(t, h, te, o)) begin
      model_num = t * 1000 + h * 100 + te * 10 + o;
      model_err = 0;
      lat = 0;
      busy_ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
        if (n > 1) begin
          @(posedge clk);
          #1;
        end else begin
          busy_ok &= bus.busy;
          @(posedge clk);
          #1;
        end
        if (bus.done) begin
          lat = n;
          break;
        end
        busy_ok &= bus.busy;
      end
      check("done_seen", {31'd0, lat != 0}, 32'd1);
      check("latency", lat, 32'd15);
      check("busy_during", {31'd0, busy_ok}, 32'd1);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("number", {18'd0, bus.number}, model_num);
      check("err_ok", {31'd0, bus.err}, 32'd0);
    end else begin
      model_err = 1;
      check("rej_done", {31'd0, bus.done}, 32'd1);
      check("rej_err", {31'd0, bus.err}, 32'd1);
      check("rej_busy", {31'd0, bus.busy}, 32'd0);
      check("rej_number", {18'd0, bus.number}, model_num);
      @(posedge clk);
      #1;
      check("rej_done_pulse", {31'd0, bus.done}, 32'd0);
      check("rej_busy_after", {31'd0, bus.busy}, 32'd0);
      check("rej_err_held", {31'd0, bus.err}, 32'd1);
    end
  endtask

  initial begin
    int dones, done_at, dg[4];
    bus.start = 1'b0;
    set_digits(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_number", {18'd0, bus.number}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(9, 9, 9, 9);
    apply(0, 0, 0, 0);
    apply(1, 2, 3, 4);
    apply(0, 0, 10, 0);
    apply(9, 0, 0, 0);
    apply(0, 0, 0, 9);

    // Starts during a conversion must be ignored.
    @(negedge clk);
    set_digits(3, 1, 4, 1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    done_at = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3 || k == 10) begin
        set_digits(8, 8, 8, 8);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (done_at == 0) done_at = k;
      end
    end
    bus.start = 1'b0;
    model_num = 3141;
    check("ign_dones", dones, 32'd1);
    check("ign_latency", done_at, 32'd15);
    check("ign_number", {18'd0, bus.number}, 32'd3141);

    // Reset in the middle of a conversion.
    @(negedge clk);
    set_digits(5, 6, 7, 8);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_number", {18'd0, bus.number}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_err", {31'd0, bus.err}, 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      dones += int'(bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_num = 0;
    model_err = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      dones += int'(bus.done);
    end
    check("arst_no_done", dones, 32'd0);
    apply(0, 0, 4, 2);

    for (int i = 0; i < 400; i++) begin
      foreach (dg[j]) dg[j] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 15))
                                                           : int'($urandom_range(0, 9));
      apply(dg[0], dg[1], dg[2], dg[3]);
    end
    apply(9, 9, 9, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
